// File: rtl/alu_exec_unit.sv
// Integer execute stage: computes one RS op per cycle, buffers results in an
// in-order queue and presents the head entry on the CDB until granted.
module alu_exec_unit #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned TAGW  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rdy,
    input  logic            flush,
    input  logic            in_valid,
    input  logic [5:0]      in_op,
    input  logic [31:0]     in_a,
    input  logic [31:0]     in_b,
    input  logic [TAGW-1:0] in_tag,
    output logic            alu_busy,
    output logic            cdb_valid,
    output logic [TAGW-1:0] cdb_tag,
    output logic [31:0]     cdb_val,
    input  logic            cdb_grant,
    output logic            err_ovf
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    localparam logic [5:0] OpAdd  = 6'd1;
    localparam logic [5:0] OpSub  = 6'd2;
    localparam logic [5:0] OpSll  = 6'd3;
    localparam logic [5:0] OpSlt  = 6'd4;
    localparam logic [5:0] OpSltu = 6'd5;
    localparam logic [5:0] OpXor  = 6'd6;
    localparam logic [5:0] OpSrl  = 6'd7;
    localparam logic [5:0] OpSra  = 6'd8;
    localparam logic [5:0] OpOr   = 6'd9;
    localparam logic [5:0] OpAnd  = 6'd10;
    localparam logic [5:0] OpBeq  = 6'd11;
    localparam logic [5:0] OpBne  = 6'd12;
    localparam logic [5:0] OpBlt  = 6'd13;
    localparam logic [5:0] OpBge  = 6'd14;
    localparam logic [5:0] OpBltu = 6'd15;
    localparam logic [5:0] OpBgeu = 6'd16;
    localparam logic [5:0] OpJalr = 6'd17;

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    logic [31:0] sum;
    logic [32:0] diff;
    logic        ltu;
    logic        lts;
    logic        eq;

    assign sum  = in_a + in_b;
    // Carry out of a + ~b + 1 is set exactly when a >= b unsigned.
    assign diff = {1'b0, in_a} + {1'b0, ~in_b} + 33'd1;
    assign ltu  = ~diff[32];
    assign lts  = (in_a[31] ^ in_b[31]) ? in_a[31] : diff[31];
    assign eq   = (in_a == in_b);

    // Single right shifter; left shifts run through it bit-reversed.
    logic [31:0] a_rev;
    logic [31:0] sh_src;
    logic        sh_fill;
    logic [31:0] sh_s0;
    logic [31:0] sh_s1;
    logic [31:0] sh_s2;
    logic [31:0] sh_s3;
    logic [31:0] shr_v;
    logic [31:0] sll_v;

    always_comb begin
        a_rev = '0;
        for (int i = 0; i < 32; i++) begin
            a_rev[i] = in_a[31-i];
        end
    end

    assign sh_src  = (in_op == OpSll) ? a_rev : in_a;
    assign sh_fill = (in_op == OpSra) & in_a[31];
    assign sh_s0   = in_b[0] ? {sh_fill, sh_src[31:1]} : sh_src;
    assign sh_s1   = in_b[1] ? {{2{sh_fill}}, sh_s0[31:2]} : sh_s0;
    assign sh_s2   = in_b[2] ? {{4{sh_fill}}, sh_s1[31:4]} : sh_s1;
    assign sh_s3   = in_b[3] ? {{8{sh_fill}}, sh_s2[31:8]} : sh_s2;
    assign shr_v   = in_b[4] ? {{16{sh_fill}}, sh_s3[31:16]} : sh_s3;

    always_comb begin
        sll_v = '0;
        for (int i = 0; i < 32; i++) begin
            sll_v[i] = shr_v[31-i];
        end
    end

    logic [31:0] result;

    always_comb begin
        result = '0;
        case (in_op)
            OpAdd:   result = sum;
            OpSub:   result = diff[31:0];
            OpSll:   result = sll_v;
            OpSlt:   result = {31'b0, lts};
            OpSltu:  result = {31'b0, ltu};
            OpXor:   result = in_a ^ in_b;
            OpSrl:   result = shr_v;
            OpSra:   result = shr_v;
            OpOr:    result = in_a | in_b;
            OpAnd:   result = in_a & in_b;
            OpBeq:   result = {31'b0, eq};
            OpBne:   result = {31'b0, ~eq};
            OpBlt:   result = {31'b0, lts};
            OpBge:   result = {31'b0, ~lts};
            OpBltu:  result = {31'b0, ltu};
            OpBgeu:  result = {31'b0, ~ltu};
            OpJalr:  result = {sum[31:1], 1'b0};
            default: result = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Result queue
    // ------------------------------------------------------------------
    logic [TAGW-1:0] tag_q [DEPTH];
    logic [31:0]     val_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            err_q, err_d;

    logic full;
    logic pop;
    logic accept;
    logic ovf_set;

    assign full      = (count_q == CW'(DEPTH));
    assign cdb_valid = (count_q != '0) & rdy;
    assign cdb_tag   = tag_q[rd_ptr_q];
    assign cdb_val   = val_q[rd_ptr_q];
    assign pop       = cdb_valid & cdb_grant;
    assign alu_busy  = full & ~pop;
    assign accept    = in_valid & rdy & ~alu_busy & ~flush;
    assign ovf_set   = in_valid & rdy & alu_busy & ~flush;
    assign err_ovf   = err_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        err_d    = err_q | ovf_set;
        if (rdy && flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            err_d    = err_q;
        end else begin
            if (accept) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(accept) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    // Entries are reset so the CDB reads zero straight out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i] <= '0;
                val_q[i] <= '0;
            end
        end else if (accept) begin
            tag_q[wr_ptr_q] <= in_tag;
            val_q[wr_ptr_q] <= result;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomised and directed bench for alu_exec_unit with a queue scoreboard.
module tb_alu_exec_unit;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned TAGW  = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            rdy = 1'b0;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic [5:0]      in_op = '0;
    logic [31:0]     in_a = '0;
    logic [31:0]     in_b = '0;
    logic [TAGW-1:0] in_tag = '0;
    logic            cdb_grant = 1'b0;
    logic            alu_busy;
    logic            cdb_valid;
    logic [TAGW-1:0] cdb_tag;
    logic [31:0]     cdb_val;
    logic            err_ovf;

    alu_exec_unit #(.DEPTH(DEPTH), .TAGW(TAGW)) dut (
        .clk      (clk),
        .rst      (rst),
        .rdy      (rdy),
        .flush    (flush),
        .in_valid (in_valid),
        .in_op    (in_op),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_tag   (in_tag),
        .alu_busy (alu_busy),
        .cdb_valid(cdb_valid),
        .cdb_tag  (cdb_tag),
        .cdb_val  (cdb_val),
        .cdb_grant(cdb_grant),
        .err_ovf  (err_ovf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [TAGW-1:0] tag;
        logic [31:0]     val;
    } exp_t;

    exp_t exp_q[$];
    logic err_exp = 1'b0;
    bit   done = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    function automatic logic [31:0] ref_alu(input logic [5:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int unsigned sh;
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sh = b % 32;
        sa = a;
        sb = b;
        case (op)
            6'd1:    return a + b;
            6'd2:    return a - b;
            6'd3:    return a << sh;
            6'd4:    return (sa < sb) ? 32'd1 : 32'd0;
            6'd5:    return (a < b) ? 32'd1 : 32'd0;
            6'd6:    return a ^ b;
            6'd7:    return a >> sh;
            6'd8:    return 32'(sa >>> sh);
            6'd9:    return a | b;
            6'd10:   return a & b;
            6'd11:   return (a == b) ? 32'd1 : 32'd0;
            6'd12:   return (a != b) ? 32'd1 : 32'd0;
            6'd13:   return (sa < sb) ? 32'd1 : 32'd0;
            6'd14:   return (sa >= sb) ? 32'd1 : 32'd0;
            6'd15:   return (a < b) ? 32'd1 : 32'd0;
            6'd16:   return (a >= b) ? 32'd1 : 32'd0;
            6'd17:   return (a + b) & 32'hFFFF_FFFE;
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares CDB/backpressure against the scoreboard, retires on grant.
    always @(negedge clk) begin
        int  sz;
        bit  pop_m;
        if (!done && rst) begin
            sz = exp_q.size();
            chk("cdb_valid", 32'(cdb_valid), 32'((sz > 0) && rdy));
            if (sz > 0) begin
                chk("cdb_tag", 32'(cdb_tag), 32'(exp_q[0].tag));
                chk("cdb_val", cdb_val, exp_q[0].val);
            end
            pop_m = (sz > 0) && rdy && cdb_grant;
            chk("alu_busy", 32'(alu_busy), 32'((sz == DEPTH) && !pop_m));
            chk("err_ovf", 32'(err_ovf), 32'(err_exp));
            if (rdy && flush) exp_q.delete();
            else if (pop_m) void'(exp_q.pop_front());
        end
    end

    task automatic drive(input logic v, input logic [5:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [TAGW-1:0] tag, input logic g,
                         input logic f, input logic r);
        in_valid  = v;
        in_op     = op;
        in_a      = a;
        in_b      = b;
        in_tag    = tag;
        cdb_grant = g;
        flush     = f;
        rdy       = r;
    endtask

    task automatic idle(input logic g);
        drive(1'b0, 6'd0, 32'd0, 32'd0, '0, g, 1'b0, 1'b1);
    endtask

    // Runs after the monitor's retire so queue occupancy reflects this cycle's pop.
    task automatic step();
        exp_t e;
        @(negedge clk);
        #1;
        if (rst && in_valid && rdy && !flush) begin
            if (exp_q.size() < DEPTH) begin
                e.tag = in_tag;
                e.val = ref_alu(in_op, in_a, in_b);
                exp_q.push_back(e);
            end else begin
                err_exp = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset_mid_cycle();
        idle(1'b0);
        #2;
        rst = 1'b0;
        #1;
        chk("rst cdb_valid", 32'(cdb_valid), 32'd0);
        chk("rst cdb_tag", 32'(cdb_tag), 32'd0);
        chk("rst cdb_val", cdb_val, 32'd0);
        chk("rst err_ovf", 32'(err_ovf), 32'd0);
        chk("rst alu_busy", 32'(alu_busy), 32'd0);
        exp_q.delete();
        err_exp = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle(1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset cdb_valid", 32'(cdb_valid), 32'd0);
        chk("reset cdb_val", cdb_val, 32'd0);
        chk("reset alu_busy", 32'(alu_busy), 32'd0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // ADD 7 + 0xFFFFFFFE wraps to 5, single-cycle latency, grant held.
        drive(1'b1, 6'd1, 32'd7, 32'hFFFF_FFFE, 4'd3, 1'b1, 1'b0, 1'b1);
        step();
        idle(1'b1);
        #1;
        chk("add valid", 32'(cdb_valid), 32'd1);
        chk("add tag", 32'(cdb_tag), 32'd3);
        chk("add val", cdb_val, 32'd5);
        step();
        idle(1'b1);
        #1;
        chk("add gone", 32'(cdb_valid), 32'd0);
        step();

        // Fill with SRA/SLTU, third op overflows.
        drive(1'b1, 6'd8, 32'h8000_0000, 32'd33, 4'd1, 1'b0, 1'b0, 1'b1);
        step();
        drive(1'b1, 6'd5, 32'd1, 32'hFFFF_FFFF, 4'd2, 1'b0, 1'b0, 1'b1);
        step();
        drive(1'b1, 6'd14, 32'hFFFF_FFFF, 32'd0, 4'd4, 1'b0, 1'b0, 1'b1);
        #1;
        chk("full busy", 32'(alu_busy), 32'd1);
        step();
        idle(1'b0);
        #1;
        chk("ovf sticky", 32'(err_ovf), 32'd1);
        step();
        idle(1'b1);
        #1;
        chk("sra val", cdb_val, 32'hC000_0000);
        step();
        idle(1'b1);
        #1;
        chk("sltu val", cdb_val, 32'd1);
        step();

        // Full queue with simultaneous pop and JALR issue.
        drive(1'b1, 6'd1, 32'd1, 32'd1, 4'd1, 1'b0, 1'b0, 1'b1);
        step();
        drive(1'b1, 6'd6, 32'hF0F0, 32'h0FF0, 4'd2, 1'b0, 1'b0, 1'b1);
        step();
        drive(1'b1, 6'd17, 32'h1001, 32'd4, 4'd9, 1'b1, 1'b0, 1'b1);
        #1;
        chk("pop unblocks", 32'(alu_busy), 32'd0);
        step();
        idle(1'b0);
        #1;
        chk("still full", 32'(alu_busy), 32'd1);
        step();
        idle(1'b1);
        step();
        idle(1'b1);
        #1;
        chk("jalr tag", 32'(cdb_tag), 32'd9);
        chk("jalr val", cdb_val, 32'h1004);
        step();

        // Flush with a concurrent issue.
        drive(1'b1, 6'd2, 32'd10, 32'd3, 4'd5, 1'b0, 1'b0, 1'b1);
        step();
        drive(1'b1, 6'd9, 32'h10, 32'h01, 4'd6, 1'b0, 1'b0, 1'b1);
        step();
        drive(1'b1, 6'd1, 32'd2, 32'd2, 4'd7, 1'b0, 1'b1, 1'b1);
        step();
        idle(1'b1);
        #1;
        chk("flush valid", 32'(cdb_valid), 32'd0);
        chk("flush busy", 32'(alu_busy), 32'd0);
        step();

        // Freeze with grant asserted holds the entry.
        drive(1'b1, 6'd3, 32'd1, 32'd31, 4'd8, 1'b0, 1'b0, 1'b1);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 6'd0, 32'd0, 32'd0, '0, 1'b1, 1'b0, 1'b0);
            #1;
            chk("freeze valid", 32'(cdb_valid), 32'd0);
            step();
        end
        idle(1'b1);
        #1;
        chk("thaw val", cdb_val, 32'h8000_0000);
        step();
        idle(1'b1);
        #1;
        chk("thaw once", 32'(cdb_valid), 32'd0);
        step();

        // Asynchronous reset with two entries queued.
        drive(1'b1, 6'd10, 32'hFF, 32'h0F, 4'd1, 1'b0, 1'b0, 1'b1);
        step();
        drive(1'b1, 6'd12, 32'd1, 32'd2, 4'd2, 1'b0, 1'b0, 1'b1);
        step();
        reset_mid_cycle();
        idle(1'b1);
        #1;
        chk("post-rst empty", 32'(cdb_valid), 32'd0);
        step();

        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 9) < 7), 6'($urandom_range(0, 20)), $urandom(),
                  (($urandom_range(0, 3) == 0) ? $urandom_range(0, 40) : $urandom()),
                  TAGW'($urandom()), ($urandom_range(0, 9) < 6),
                  ($urandom_range(0, 31) == 0), ($urandom_range(0, 7) != 0));
            step();
        end
        for (int i = 0; i < DEPTH + 2; i++) begin
            idle(1'b1);
            step();
        end

        done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Integer execute stage directly downstream of the reservation station.
- Each cycle it accepts at most one ready operation from the RS: opcode, two operand values and the destination ROB tag.
- Computes the result, buffers it in a small in-order result queue, and drives it onto the common data bus (CDB) once the bus arbiter grants.
- Asserts backpressure to the RS when the queue cannot absorb another result.

Parameters:
- DEPTH, 2, result-queue entries (power of two, >=2).
- TAGW, 4, ROB tag width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- rdy  in  1  global enable; low = freeze.
- flush  in  1  mispredict flush; synchronous clear.
- in_valid  in  1  RS issues an op this cycle.
- in_op  in  6  internal opcode.
- in_a  in  32  operand 1 value.
- in_b  in  32  operand 2 value (register or immediate).
- in_tag  in  TAGW  destination ROB tag.
- alu_busy  out  1  RS must not issue this cycle.
- cdb_valid  out  1  result presented on CDB.
- cdb_tag  out  TAGW  ROB tag of presented result.
- cdb_val  out  32  presented result.
- cdb_grant  in  1  arbiter accepts the presented result this cycle.
- err_ovf  out  1  sticky: op arrived while busy.

Behaviour:
- Reset (rst=0, asynchronous): queue empty, rd/wr pointers 0, count 0. Outputs: cdb_valid=0, cdb_tag=0, cdb_val=0, err_ovf=0, alu_busy=0.
- Opcodes (6-bit, unsigned):
  - 1 ADD a+b; 2 SUB a-b; 3 SLL a<<b[4:0]; 4 SLT signed a<b ->1/0; 5 SLTU unsigned.
  - 6 XOR; 7 SRL logical; 8 SRA arithmetic (shift amount b[4:0]); 9 OR; 10 AND.
  - 11 BEQ, 12 BNE, 13 BLT (signed), 14 BGE (signed), 15 BLTU, 16 BGEU: result = 32'd1 if taken else 32'd0.
  - 17 JALR: (a+b)&~1.
  - Any other opcode: result 0 (still enqueued and broadcast).
- Arithmetic is 32-bit modulo 2^32; overflow is ignored.
- pop = cdb_valid & cdb_grant & rdy.
- alu_busy = (count==DEPTH) & ~pop. This output is combinational.
- Accept when in_valid & rdy & ~alu_busy & ~flush. On accept, the result is computed combinationally and written at the tail on that clock edge.
- Latency: an op accepted in cycle T is visible on the CDB in cycle T+1 if the queue was empty (or popped in T).
- CDB outputs come directly from the head entry: cdb_valid = (count!=0) & rdy. cdb_tag and cdb_val must be held stable until granted.
- Order: strictly FIFO; results are broadcast in acceptance order.
- Simultaneous accept+pop: count is unchanged. A full queue with pop accepts the new op in the same cycle.
- Wrap-around: pointers wrap modulo DEPTH.
- in_valid while alu_busy (or while flush): the op is dropped. If not flushing, err_ovf sets and stays set until reset.
- flush=1 (with rdy=1): empty the queue at the edge, with no accept and no pop that cycle. cdb_valid=0 from the next cycle. flush has priority over every other event.
- rdy=0: all state is held, no accept, no pop, and flush is ignored. cdb_valid is driven 0; cdb_tag/cdb_val hold their head values.
- Reset mid-operation discards all queued results immediately.

Test Plan:
- ADD a=7 b=0xFFFFFFFE tag=3, grant held high -> next cycle cdb_valid=1, tag=3, val=5; the following cycle cdb_valid=0.
- SRA a=0x80000000 b=33, then SLTU a=1 b=0xFFFFFFFF, then BGE a=-1 b=0 on consecutive cycles, grant low for 4 cycles:
  - After the 2nd accept alu_busy=1 and the 3rd op drops with err_ovf=1.
  - Raise grant -> 0xC0000000 then 1 are broadcast in order.
- Queue full, grant=1 and in_valid on the same cycle (JALR a=0x1001 b=4, tag=9) -> head pops, JALR is accepted, alu_busy=0, count stays 2. Later broadcast 0x1004 tag 9.
- Two results queued, flush=1 together with in_valid -> next cycle cdb_valid=0, count 0, new op not enqueued, err_ovf unchanged.
- rdy=0 for 3 cycles with one result queued and grant=1 -> cdb_valid=0, nothing lost. When rdy returns, the result is broadcast once.
- Assert rst=0 asynchronously mid-cycle with 2 entries -> all outputs 0 before the next edge, and the queue stays empty after release.
